decode_issue_unit: RTL and testbench
====================================

Name: decode_issue_unit

Overview:
- Parametrised decode/issue stage for the out-of-order RV32I core; sits between IFetch and RS/LSB/ROB.
- Buffers fetched instructions in a DEPTH-entry queue and decodes the head.
- Resolves operands against regfile and ROB, allocates the ROB tag, and issues one instruction per cycle over registered valid/ready channels.
- Adds back-pressure, flush and illegal-instruction detection.

Parameters:
- ROB_W, 4, ROB tag width (ROB depth 2^ROB_W).
- DEPTH, 4, instruction queue entries (power of two, ≥2).
- OP_W, 6, internal op encoding width (encodings from the shared define header).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when low, no state changes
- flush  in  1  mispredict flush from ROB
- if_valid  in  1  fetch offers instruction
- if_instr  in  32  instruction
- if_pc  in  32  instruction PC
- if_ready  out  1  queue not full
- reg_rs1_idx, reg_rs2_idx  out  5  head source registers (combinational)
- reg_rs1_val, reg_rs2_val  in  32  regfile values
- reg_rs1_busy, reg_rs2_busy  in  1  register renamed
- reg_rs1_tag, reg_rs2_tag  in  ROB_W  rename tags
- rob_q1_tag, rob_q2_tag  out  ROB_W  ROB lookup indices (= reg tags)
- rob_q1_ready, rob_q2_ready  in  1  ROB entry has result
- rob_q1_val, rob_q2_val  in  32  ROB results
- rob_free_valid  in  1  ROB has a free entry
- rob_free_tag  in  ROB_W  next free ROB tag
- rename_we  out  1  issue strobe; regfile renames rd this edge
- rename_rd  out  5  rd being renamed
- rename_tag  out  ROB_W  tag bound to rd
- rs_valid, lsb_valid, rob_valid  out  1  registered issue valids
- rs_ready, lsb_ready  in  1  unit has a free slot
- iss_op  out  OP_W  decoded op
- iss_pc, iss_imm  out  32  PC; sign-extended immediate
- iss_v1, iss_v2  out  32  operand values
- iss_q1v, iss_q2v  out  1  operand still pending
- iss_q1, iss_q2  out  ROB_W  pending tags
- iss_tag  out  ROB_W  allocated ROB tag
- iss_rd  out  5  destination (0 for branch/store)
- iss_illegal  out  1  undecodable instruction (ROB only)

Behaviour:
- Reset (rst=0, async): queue empty, head/tail/count=0, all valids 0, iss_* 0, if_ready=1.
- Queue: enqueue on if_valid && if_ready && rdy. if_ready = count<DEPTH. Pointers wrap modulo DEPTH. Simultaneous enqueue+dequeue while full is not allowed (if_ready=0). Simultaneous enqueue+dequeue otherwise keeps count unchanged.
- Decode (combinational on head): LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Immediate formats I/S/B/U/J, sign-extended from bit 31.
  - SRLI/SRAI and ADD/SUB/SRL/SRA are selected by funct7 bit 30.
  - Undefined opcode or funct3/funct7 combination: op=NOP, illegal=1, rd=0, no sources.
- Target unit: LOAD/STORE go to LSB. Everything else, except illegal instructions, goes to RS. Every instruction goes to the ROB.
- Operand resolution, per source:
  - index 0 or unused: value 0, qv=0.
  - not busy: reg value, qv=0.
  - busy and ROB ready: ROB value, qv=0.
  - otherwise: qv=1, q=reg tag.
- fire = rdy && !flush && count>0 && rob_free_valid && (target unit ready, or illegal).
- On fire:
  - dequeue head.
  - next edge: iss_* registered; rob_valid=1; rs_valid or lsb_valid=1 per target.
  - iss_tag=rob_free_tag.
  - rename_we=fire (combinational) when rd≠0 and the op writes rd.
- Without fire, all valids deassert next edge (single-cycle pulses). Issue latency: head present → valid is 1 cycle.
- Back-to-back dependent instructions: the regfile renames on the rename_we edge, so the next head sees busy with the new tag.
- flush (when rdy): next edge queue empty, valids 0, no rename_we. An enqueue in the same cycle is dropped. flush dominates fire.
- rdy=0: outputs hold, no enqueue or dequeue, rename_we=0.
- Reset mid-operation: everything returns to reset values immediately; a partial issue is lost.

Test Plan:
- Reset, then enqueue 0x00500093 (addi x1,x0,5) at pc 0x0, regs idle, rob_free_tag=3 → 1 cycle later rs_valid=rob_valid=1, op=ADDI, imm=5, v1=0, q1v=0, iss_tag=3, iss_rd=1; rename_we pulsed with rd=1.
- Enqueue 0x0080A103 (lw x2,8(x1)) with x1 busy tag 3, rob_q1_ready=0 → lsb_valid=1, q1v=1, q1=3, imm=8, rd=2. Repeat with rob_q1_ready=1, val 0x100 → v1=0x100, q1v=0.
- Enqueue 0x0020A223 (sw x2,4(x1)) with lsb_ready=0 for 3 cycles → no valid while stalled; issues on the cycle after lsb_ready=1; imm=4, iss_rd=0, no rename_we.
- Fill DEPTH=4 entries with rs_ready=0 → if_ready=0, a 5th if_valid is ignored. Release → 4 issues on consecutive cycles in order, pointers wrap.
- 2 queued entries, assert flush together with if_valid → next cycle count=0, no valids, if_ready=1.
- Enqueue 0xFFFFFFFF → rob_valid=1, iss_illegal=1, rs_valid=lsb_valid=0, no rename_we.

Source files
------------

// File: rtl/decode_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_unit
//  Desc     : RV32I decode/issue stage. Queues fetched instructions, decodes
//             the head, resolves operands against regfile/ROB, allocates a
//             ROB tag and issues one instruction per cycle to RS/LSB/ROB.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_issue_unit #(
    parameter int ROB_W = 4,
    parameter int DEPTH = 4,
    parameter int OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    output logic             if_ready,
    output logic [4:0]       reg_rs1_idx,
    output logic [4:0]       reg_rs2_idx,
    input  logic [31:0]      reg_rs1_val,
    input  logic [31:0]      reg_rs2_val,
    input  logic             reg_rs1_busy,
    input  logic             reg_rs2_busy,
    input  logic [ROB_W-1:0] reg_rs1_tag,
    input  logic [ROB_W-1:0] reg_rs2_tag,
    output logic [ROB_W-1:0] rob_q1_tag,
    output logic [ROB_W-1:0] rob_q2_tag,
    input  logic             rob_q1_ready,
    input  logic             rob_q2_ready,
    input  logic [31:0]      rob_q1_val,
    input  logic [31:0]      rob_q2_val,
    input  logic             rob_free_valid,
    input  logic [ROB_W-1:0] rob_free_tag,
    output logic             rename_we,
    output logic [4:0]       rename_rd,
    output logic [ROB_W-1:0] rename_tag,
    output logic             rs_valid,
    output logic             lsb_valid,
    output logic             rob_valid,
    input  logic             rs_ready,
    input  logic             lsb_ready,
    output logic [OP_W-1:0]  iss_op,
    output logic [31:0]      iss_pc,
    output logic [31:0]      iss_imm,
    output logic [31:0]      iss_v1,
    output logic [31:0]      iss_v2,
    output logic             iss_q1v,
    output logic             iss_q2v,
    output logic [ROB_W-1:0] iss_q1,
    output logic [ROB_W-1:0] iss_q2,
    output logic [ROB_W-1:0] iss_tag,
    output logic [4:0]       iss_rd,
    output logic             iss_illegal
);

    localparam int              c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(DEPTH);

    // RV32I major opcodes
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;

    // Internal op encodings
    localparam logic [OP_W-1:0] c_op_nop   = OP_W'(0);
    localparam logic [OP_W-1:0] c_op_lui   = OP_W'(1);
    localparam logic [OP_W-1:0] c_op_auipc = OP_W'(2);
    localparam logic [OP_W-1:0] c_op_jal   = OP_W'(3);
    localparam logic [OP_W-1:0] c_op_jalr  = OP_W'(4);
    localparam logic [OP_W-1:0] c_op_beq   = OP_W'(5);
    localparam logic [OP_W-1:0] c_op_bne   = OP_W'(6);
    localparam logic [OP_W-1:0] c_op_blt   = OP_W'(7);
    localparam logic [OP_W-1:0] c_op_bge   = OP_W'(8);
    localparam logic [OP_W-1:0] c_op_bltu  = OP_W'(9);
    localparam logic [OP_W-1:0] c_op_bgeu  = OP_W'(10);
    localparam logic [OP_W-1:0] c_op_lb    = OP_W'(11);
    localparam logic [OP_W-1:0] c_op_lh    = OP_W'(12);
    localparam logic [OP_W-1:0] c_op_lw    = OP_W'(13);
    localparam logic [OP_W-1:0] c_op_lbu   = OP_W'(14);
    localparam logic [OP_W-1:0] c_op_lhu   = OP_W'(15);
    localparam logic [OP_W-1:0] c_op_sb    = OP_W'(16);
    localparam logic [OP_W-1:0] c_op_sh    = OP_W'(17);
    localparam logic [OP_W-1:0] c_op_sw    = OP_W'(18);
    localparam logic [OP_W-1:0] c_op_addi  = OP_W'(19);
    localparam logic [OP_W-1:0] c_op_slti  = OP_W'(20);
    localparam logic [OP_W-1:0] c_op_sltiu = OP_W'(21);
    localparam logic [OP_W-1:0] c_op_xori  = OP_W'(22);
    localparam logic [OP_W-1:0] c_op_ori   = OP_W'(23);
    localparam logic [OP_W-1:0] c_op_andi  = OP_W'(24);
    localparam logic [OP_W-1:0] c_op_slli  = OP_W'(25);
    localparam logic [OP_W-1:0] c_op_srli  = OP_W'(26);
    localparam logic [OP_W-1:0] c_op_srai  = OP_W'(27);
    localparam logic [OP_W-1:0] c_op_add   = OP_W'(28);
    localparam logic [OP_W-1:0] c_op_sub   = OP_W'(29);
    localparam logic [OP_W-1:0] c_op_sll   = OP_W'(30);
    localparam logic [OP_W-1:0] c_op_slt   = OP_W'(31);
    localparam logic [OP_W-1:0] c_op_sltu  = OP_W'(32);
    localparam logic [OP_W-1:0] c_op_xor   = OP_W'(33);
    localparam logic [OP_W-1:0] c_op_srl   = OP_W'(34);
    localparam logic [OP_W-1:0] c_op_sra   = OP_W'(35);
    localparam logic [OP_W-1:0] c_op_or    = OP_W'(36);
    localparam logic [OP_W-1:0] c_op_and   = OP_W'(37);

    // Instruction queue storage and control
    logic [31:0]        r_q_instr [DEPTH];
    logic [31:0]        r_q_pc    [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;

    // Issue registers
    logic               r_rs_valid, r_lsb_valid, r_rob_valid;
    logic [OP_W-1:0]    r_op;
    logic [31:0]        r_pc, r_imm, r_v1, r_v2;
    logic               r_q1v, r_q2v, r_illegal;
    logic [ROB_W-1:0]   r_q1, r_q2, r_tag;
    logic [4:0]         r_rd;

    // Head decode
    logic [31:0]        w_ins;
    logic [31:0]        w_pc;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [31:0]        w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [OP_W-1:0]    w_op;
    logic [31:0]        w_imm;
    logic               w_illegal, w_use1, w_use2, w_wr, w_is_ls;
    logic [4:0]         w_rd;

    // Operand resolution, handshake
    logic [4:0]         w_rs1_idx, w_rs2_idx;
    logic [31:0]        w_v1, w_v2;
    logic               w_q1v, w_q2v;
    logic [ROB_W-1:0]   w_q1, w_q2;
    logic               w_unit_ready, w_fire, w_enq;

    assign w_ins   = r_q_instr[r_head];
    assign w_pc    = r_q_pc[r_head];
    assign w_f3    = w_ins[14:12];
    assign w_f7    = w_ins[31:25];
    assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
    assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
    assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
    assign w_imm_u = {w_ins[31:12], 12'b0};
    assign w_imm_j = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

    // Decode the queue head into op, immediate, source usage and target unit
    always_comb begin
        w_op      = c_op_nop;
        w_imm     = 32'd0;
        w_illegal = 1'b0;
        w_use1    = 1'b0;
        w_use2    = 1'b0;
        w_wr      = 1'b0;
        w_is_ls   = 1'b0;
        case (w_ins[6:0])
            c_opc_lui:   begin w_op = c_op_lui;   w_imm = w_imm_u; w_wr = 1'b1; end
            c_opc_auipc: begin w_op = c_op_auipc; w_imm = w_imm_u; w_wr = 1'b1; end
            c_opc_jal:   begin w_op = c_op_jal;   w_imm = w_imm_j; w_wr = 1'b1; end
            c_opc_jalr: begin
                w_op = c_op_jalr; w_imm = w_imm_i; w_use1 = 1'b1; w_wr = 1'b1;
                w_illegal = (w_f3 != 3'd0);
            end
            c_opc_branch: begin
                w_imm = w_imm_b; w_use1 = 1'b1; w_use2 = 1'b1;
                case (w_f3)
                    3'd0:    w_op = c_op_beq;
                    3'd1:    w_op = c_op_bne;
                    3'd4:    w_op = c_op_blt;
                    3'd5:    w_op = c_op_bge;
                    3'd6:    w_op = c_op_bltu;
                    3'd7:    w_op = c_op_bgeu;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_opc_load: begin
                w_imm = w_imm_i; w_use1 = 1'b1; w_wr = 1'b1; w_is_ls = 1'b1;
                case (w_f3)
                    3'd0:    w_op = c_op_lb;
                    3'd1:    w_op = c_op_lh;
                    3'd2:    w_op = c_op_lw;
                    3'd4:    w_op = c_op_lbu;
                    3'd5:    w_op = c_op_lhu;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_opc_store: begin
                w_imm = w_imm_s; w_use1 = 1'b1; w_use2 = 1'b1; w_is_ls = 1'b1;
                case (w_f3)
                    3'd0:    w_op = c_op_sb;
                    3'd1:    w_op = c_op_sh;
                    3'd2:    w_op = c_op_sw;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_opc_opimm: begin
                w_imm = w_imm_i; w_use1 = 1'b1; w_wr = 1'b1;
                case (w_f3)
                    3'd0: w_op = c_op_addi;
                    3'd2: w_op = c_op_slti;
                    3'd3: w_op = c_op_sltiu;
                    3'd4: w_op = c_op_xori;
                    3'd6: w_op = c_op_ori;
                    3'd7: w_op = c_op_andi;
                    3'd1: begin
                        w_op = c_op_slli;
                        w_illegal = (w_f7 != 7'b0000000);
                    end
                    default: begin
                        // funct3=101: bit 30 of funct7 picks arithmetic shift
                        w_op = w_f7[5] ? c_op_srai : c_op_srli;
                        w_illegal = ({w_f7[6], w_f7[4:0]} != 6'd0);
                    end
                endcase
            end
            c_opc_op: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_wr = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'd0:    w_op = c_op_add;
                        3'd1:    w_op = c_op_sll;
                        3'd2:    w_op = c_op_slt;
                        3'd3:    w_op = c_op_sltu;
                        3'd4:    w_op = c_op_xor;
                        3'd5:    w_op = c_op_srl;
                        3'd6:    w_op = c_op_or;
                        default: w_op = c_op_and;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'd0) begin
                    w_op = c_op_sub;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'd5) begin
                    w_op = c_op_sra;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        // An illegal word carries nothing but its PC to the ROB
        if (w_illegal) begin
            w_op    = c_op_nop;
            w_imm   = 32'd0;
            w_use1  = 1'b0;
            w_use2  = 1'b0;
            w_wr    = 1'b0;
            w_is_ls = 1'b0;
        end
    end

    assign w_rd      = w_wr ? w_ins[11:7] : 5'd0;
    assign w_rs1_idx = w_use1 ? w_ins[19:15] : 5'd0;
    assign w_rs2_idx = w_use2 ? w_ins[24:20] : 5'd0;

    // Resolve each source: x0/unused, regfile, ROB forward, or wait on tag
    always_comb begin
        w_v1 = 32'd0; w_q1v = 1'b0; w_q1 = '0;
        w_v2 = 32'd0; w_q2v = 1'b0; w_q2 = '0;
        if (w_rs1_idx != 5'd0) begin
            if (!reg_rs1_busy)     w_v1 = reg_rs1_val;
            else if (rob_q1_ready) w_v1 = rob_q1_val;
            else begin w_q1v = 1'b1; w_q1 = reg_rs1_tag; end
        end
        if (w_rs2_idx != 5'd0) begin
            if (!reg_rs2_busy)     w_v2 = reg_rs2_val;
            else if (rob_q2_ready) w_v2 = rob_q2_val;
            else begin w_q2v = 1'b1; w_q2 = reg_rs2_tag; end
        end
    end

    // Illegal words bypass RS/LSB, so only the ROB slot gates them
    assign w_unit_ready = w_illegal | (w_is_ls ? lsb_ready : rs_ready);
    assign w_fire = rdy & ~flush & (r_count != '0) & rob_free_valid & w_unit_ready;
    assign w_enq  = rdy & ~flush & if_valid & if_ready;

    assign if_ready    = (r_count != c_full);
    assign reg_rs1_idx = w_rs1_idx;
    assign reg_rs2_idx = w_rs2_idx;
    assign rob_q1_tag  = reg_rs1_tag;
    assign rob_q2_tag  = reg_rs2_tag;
    assign rename_we   = w_fire & (w_rd != 5'd0);
    assign rename_rd   = w_rd;
    assign rename_tag  = rob_free_tag;

    // Queue payload write; contents need no reset since count gates use
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_instr[r_tail] <= if_instr;
            r_q_pc[r_tail]    <= if_pc;
        end
    end

    // Queue pointers and occupancy; flush empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq)  r_tail <= r_tail + 1'b1;
                if (w_fire) r_head <= r_head + 1'b1;
                if (w_enq && !w_fire)      r_count <= r_count + 1'b1;
                else if (!w_enq && w_fire) r_count <= r_count - 1'b1;
            end
        end
    end

    // Issue registers: single-cycle valid pulses, payload captured on fire
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs_valid  <= 1'b0;
            r_lsb_valid <= 1'b0;
            r_rob_valid <= 1'b0;
            r_op        <= c_op_nop;
            r_pc        <= 32'd0;
            r_imm       <= 32'd0;
            r_v1        <= 32'd0;
            r_v2        <= 32'd0;
            r_q1v       <= 1'b0;
            r_q2v       <= 1'b0;
            r_q1        <= '0;
            r_q2        <= '0;
            r_tag       <= '0;
            r_rd        <= 5'd0;
            r_illegal   <= 1'b0;
        end else if (rdy) begin
            r_rob_valid <= w_fire;
            r_rs_valid  <= w_fire & ~w_illegal & ~w_is_ls;
            r_lsb_valid <= w_fire & ~w_illegal & w_is_ls;
            if (w_fire) begin
                r_op      <= w_op;
                r_pc      <= w_pc;
                r_imm     <= w_imm;
                r_v1      <= w_v1;
                r_v2      <= w_v2;
                r_q1v     <= w_q1v;
                r_q2v     <= w_q2v;
                r_q1      <= w_q1;
                r_q2      <= w_q2;
                r_tag     <= rob_free_tag;
                r_rd      <= w_rd;
                r_illegal <= w_illegal;
            end
        end
    end

    assign rs_valid    = r_rs_valid;
    assign lsb_valid   = r_lsb_valid;
    assign rob_valid   = r_rob_valid;
    assign iss_op      = r_op;
    assign iss_pc      = r_pc;
    assign iss_imm     = r_imm;
    assign iss_v1      = r_v1;
    assign iss_v2      = r_v2;
    assign iss_q1v     = r_q1v;
    assign iss_q2v     = r_q2v;
    assign iss_q1      = r_q1;
    assign iss_q2      = r_q2;
    assign iss_tag     = r_tag;
    assign iss_rd      = r_rd;
    assign iss_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_issue_unit
//  Desc     : Self-checking bench for decode_issue_unit: directed scenarios
//             plus randomized instructions against a mnemonic-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue_unit;

    localparam int ROB_W = 4;
    localparam int DEPTH = 4;
    localparam int OP_W  = 6;

    localparam int OP_NOP = 0, OP_LUI = 1, OP_AUIPC = 2, OP_JAL = 3, OP_JALR = 4;
    localparam int OP_LW = 13, OP_SW = 18, OP_ADDI = 19, OP_SLLI = 25, OP_SRLI = 26;
    localparam int OP_SRAI = 27, OP_SUB = 29, OP_SRA = 35;

    // Mnemonic tables indexed by funct3 (-1 = undefined)
    int br_t [8] = '{5, 6, -1, -1, 7, 8, 9, 10};
    int ld_t [8] = '{11, 12, 13, -1, 14, 15, -1, -1};
    int st_t [8] = '{16, 17, 18, -1, -1, -1, -1, -1};
    int oi_t [8] = '{19, -1, 20, 21, 22, -1, 23, 24};
    int op_t [8] = '{28, 30, 31, 32, 33, 34, 36, 37};

    logic             clk = 1'b0;
    logic             rst, rdy, flush, if_valid, if_ready;
    logic [31:0]      if_instr, if_pc;
    logic [4:0]       reg_rs1_idx, reg_rs2_idx;
    logic [31:0]      reg_rs1_val, reg_rs2_val;
    logic             reg_rs1_busy, reg_rs2_busy;
    logic [ROB_W-1:0] reg_rs1_tag, reg_rs2_tag, rob_q1_tag, rob_q2_tag;
    logic             rob_q1_ready, rob_q2_ready;
    logic [31:0]      rob_q1_val, rob_q2_val;
    logic             rob_free_valid;
    logic [ROB_W-1:0] rob_free_tag;
    logic             rename_we;
    logic [4:0]       rename_rd;
    logic [ROB_W-1:0] rename_tag;
    logic             rs_valid, lsb_valid, rob_valid, rs_ready, lsb_ready;
    logic [OP_W-1:0]  iss_op;
    logic [31:0]      iss_pc, iss_imm, iss_v1, iss_v2;
    logic             iss_q1v, iss_q2v;
    logic [ROB_W-1:0] iss_q1, iss_q2, iss_tag;
    logic [4:0]       iss_rd;
    logic             iss_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    decode_issue_unit #(.ROB_W(ROB_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .reg_rs1_idx(reg_rs1_idx), .reg_rs2_idx(reg_rs2_idx),
        .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
        .reg_rs1_busy(reg_rs1_busy), .reg_rs2_busy(reg_rs2_busy),
        .reg_rs1_tag(reg_rs1_tag), .reg_rs2_tag(reg_rs2_tag),
        .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
        .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
        .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
        .rob_free_valid(rob_free_valid), .rob_free_tag(rob_free_tag),
        .rename_we(rename_we), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .rs_valid(rs_valid), .lsb_valid(lsb_valid), .rob_valid(rob_valid),
        .rs_ready(rs_ready), .lsb_ready(lsb_ready),
        .iss_op(iss_op), .iss_pc(iss_pc), .iss_imm(iss_imm),
        .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_q1v(iss_q1v), .iss_q2v(iss_q2v),
        .iss_q1(iss_q1), .iss_q2(iss_q2), .iss_tag(iss_tag), .iss_rd(iss_rd),
        .iss_illegal(iss_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic [31:0] x;
        x = v & ((32'd1 << n) - 32'd1);
        return x[n-1] ? x - (32'd1 << n) : x;
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output int op,
                                       output logic [31:0] imm, output logic [4:0] rd,
                                       output bit u1, output bit u2, output bit ill,
                                       output bit ls);
        int f3, f7;
        bit wr;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        op = -1; imm = 0; u1 = 0; u2 = 0; ls = 0; wr = 0;
        case (ins[6:0])
            7'h37: begin op = OP_LUI;   imm = ins & 32'hFFFF_F000; wr = 1; end
            7'h17: begin op = OP_AUIPC; imm = ins & 32'hFFFF_F000; wr = 1; end
            7'h6F: begin
                op = OP_JAL; wr = 1;
                imm = sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                           (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
            end
            7'h67: if (f3 == 0) begin op = OP_JALR; imm = sext(ins >> 20, 12); u1 = 1; wr = 1; end
            7'h63: begin
                op = br_t[f3]; u1 = 1; u2 = 1;
                imm = sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                           (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
            end
            7'h03: begin op = ld_t[f3]; imm = sext(ins >> 20, 12); u1 = 1; wr = 1; ls = 1; end
            7'h23: begin
                op = st_t[f3]; u1 = 1; u2 = 1; ls = 1;
                imm = sext(((ins >> 25) << 5) | ((ins >> 7) & 31), 12);
            end
            7'h13: begin
                imm = sext(ins >> 20, 12); u1 = 1; wr = 1;
                if (f3 == 1)      op = (f7 == 0) ? OP_SLLI : -1;
                else if (f3 == 5) op = (f7 == 0) ? OP_SRLI : (f7 == 32) ? OP_SRAI : -1;
                else              op = oi_t[f3];
            end
            7'h33: begin
                u1 = 1; u2 = 1; wr = 1;
                if (f7 == 0)       op = op_t[f3];
                else if (f7 == 32) op = (f3 == 0) ? OP_SUB : (f3 == 5) ? OP_SRA : -1;
            end
            default: op = -1;
        endcase
        ill = (op < 0);
        if (ill) begin
            op = OP_NOP; imm = 0; u1 = 0; u2 = 0; ls = 0; rd = 0;
        end else begin
            rd = wr ? ins[11:7] : 5'd0;
        end
    endfunction

    function automatic void ref_operand(input bit used, input logic [4:0] idx, input bit busy,
                                        input logic [ROB_W-1:0] tag, input logic [31:0] rv,
                                        input bit rr, input logic [31:0] robv,
                                        output logic [31:0] v, output bit qv,
                                        output logic [ROB_W-1:0] q);
        v = 0; qv = 0; q = 0;
        if (used && idx != 0) begin
            if (!busy)   v = rv;
            else if (rr) v = robv;
            else begin qv = 1; q = tag; end
        end
    endfunction

    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rdy = 1; flush = 0; if_valid = 0; if_instr = 0; if_pc = 0;
        reg_rs1_val = 0; reg_rs2_val = 0; reg_rs1_busy = 0; reg_rs2_busy = 0;
        reg_rs1_tag = 0; reg_rs2_tag = 0; rob_q1_ready = 0; rob_q2_ready = 0;
        rob_q1_val = 0; rob_q2_val = 0; rob_free_valid = 1; rob_free_tag = 3;
        rs_ready = 1; lsb_ready = 1;
    endtask

    task automatic enq(input logic [31:0] ins, input logic [31:0] pc);
        if_instr = ins; if_pc = pc; if_valid = 1;
        tick();
        if_valid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0; set_idle();
        tick(); tick();
        n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== 3'b000) begin n_fail++;
            $display("FAIL reset_valids: got %b want 000", {rs_valid, lsb_valid, rob_valid}); end
        n_tests++; if ({iss_op, iss_tag, iss_rd, iss_illegal} !== '0 || iss_imm !== 0 || iss_pc !== 0) begin n_fail++;
            $display("FAIL reset_iss: got op=%0d tag=%0d rd=%0d imm=%h want 0", iss_op, iss_tag, iss_rd, iss_imm); end
        n_tests++; if (if_ready !== 1'b1 || rename_we !== 1'b0) begin n_fail++;
            $display("FAIL reset_ready: got if_ready=%b rename_we=%b want 1/0", if_ready, rename_we); end
        rst = 1;
        tick();
    endtask

    task automatic test_addi();
        set_idle();
        enq(32'h0050_0093, 32'h0);
        @(negedge clk);
        n_tests++; if ({rename_we, rename_rd, rename_tag} !== {1'b1, 5'd1, 4'd3}) begin n_fail++;
            $display("FAIL addi_rename: got we=%b rd=%0d tag=%0d want 1/1/3", rename_we, rename_rd, rename_tag); end
        tick();
        n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== 3'b101) begin n_fail++;
            $display("FAIL addi_valids: got %b want 101", {rs_valid, lsb_valid, rob_valid}); end
        n_tests++; if (iss_op !== 6'(OP_ADDI) || iss_imm !== 32'd5 || iss_v1 !== 0 || iss_q1v !== 0) begin n_fail++;
            $display("FAIL addi_payload: got op=%0d imm=%h v1=%h q1v=%b want 19/5/0/0", iss_op, iss_imm, iss_v1, iss_q1v); end
        n_tests++; if (iss_tag !== 4'd3 || iss_rd !== 5'd1 || iss_pc !== 0 || iss_illegal !== 0) begin n_fail++;
            $display("FAIL addi_tag_rd: got tag=%0d rd=%0d pc=%h ill=%b want 3/1/0/0", iss_tag, iss_rd, iss_pc, iss_illegal); end
        tick();
        n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== 3'b000) begin n_fail++;
            $display("FAIL addi_pulse: got %b want 000", {rs_valid, lsb_valid, rob_valid}); end
    endtask

    task automatic test_load_operands();
        set_idle();
        reg_rs1_busy = 1; reg_rs1_tag = 3; rob_q1_ready = 0; rob_free_tag = 4;
        enq(32'h0080_A103, 32'h4);
        @(negedge clk);
        n_tests++; if (reg_rs1_idx !== 5'd1 || rob_q1_tag !== 4'd3 || rename_rd !== 5'd2 || rename_we !== 1) begin n_fail++;
            $display("FAIL lw_lookup: got idx=%0d qtag=%0d rd=%0d we=%b want 1/3/2/1", reg_rs1_idx, rob_q1_tag, rename_rd, rename_we); end
        tick();
        n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== 3'b011 || iss_op !== 6'(OP_LW)) begin n_fail++;
            $display("FAIL lw_valids: got %b op=%0d want 011 op=13", {rs_valid, lsb_valid, rob_valid}, iss_op); end
        n_tests++; if (iss_q1v !== 1 || iss_q1 !== 4'd3 || iss_imm !== 32'd8 || iss_rd !== 5'd2) begin n_fail++;
            $display("FAIL lw_pending: got q1v=%b q1=%0d imm=%h rd=%0d want 1/3/8/2", iss_q1v, iss_q1, iss_imm, iss_rd); end
        rob_q1_ready = 1; rob_q1_val = 32'h100;
        enq(32'h0080_A103, 32'h8);
        tick();
        n_tests++; if (lsb_valid !== 1 || iss_v1 !== 32'h100 || iss_q1v !== 0) begin n_fail++;
            $display("FAIL lw_forward: got lsb=%b v1=%h q1v=%b want 1/100/0", lsb_valid, iss_v1, iss_q1v); end
    endtask

    task automatic test_store_stall();
        set_idle();
        lsb_ready = 0; reg_rs1_val = 32'h40; reg_rs2_val = 32'hDEAD;
        enq(32'h0020_A223, 32'hC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (rename_we !== 0) begin n_fail++;
                $display("FAIL sw_stall_we: got %b want 0", rename_we); end
            tick();
            n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== 3'b000) begin n_fail++;
                $display("FAIL sw_stall_valid: got %b want 000", {rs_valid, lsb_valid, rob_valid}); end
        end
        lsb_ready = 1;
        @(negedge clk);
        n_tests++; if (rename_we !== 0) begin n_fail++;
            $display("FAIL sw_rename: got %b want 0", rename_we); end
        tick();
        n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== 3'b011 || iss_op !== 6'(OP_SW)) begin n_fail++;
            $display("FAIL sw_issue: got %b op=%0d want 011 op=18", {rs_valid, lsb_valid, rob_valid}, iss_op); end
        n_tests++; if (iss_imm !== 32'd4 || iss_rd !== 0 || iss_v1 !== 32'h40 || iss_v2 !== 32'hDEAD) begin n_fail++;
            $display("FAIL sw_payload: got imm=%h rd=%0d v1=%h v2=%h want 4/0/40/dead", iss_imm, iss_rd, iss_v1, iss_v2); end
    endtask

    task automatic test_fill_wrap();
        set_idle();
        rs_ready = 0;
        for (int k = 0; k < DEPTH; k++) enq(enc_addi(5 + k, 0, k), 32'(16 * k));
        n_tests++; if (if_ready !== 0) begin n_fail++;
            $display("FAIL fill_full: got if_ready=%b want 0", if_ready); end
        enq(enc_addi(9, 0, 9), 32'h100);
        rs_ready = 1;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            n_tests++; if (rename_we !== 1 || rename_rd !== 5'(5 + k)) begin n_fail++;
                $display("FAIL fill_rename_%0d: got we=%b rd=%0d want 1/%0d", k, rename_we, rename_rd, 5 + k); end
            tick();
            n_tests++; if (rs_valid !== 1 || iss_rd !== 5'(5 + k) || iss_imm !== 32'(k) || iss_pc !== 32'(16 * k)) begin n_fail++;
                $display("FAIL fill_issue_%0d: got v=%b rd=%0d imm=%h pc=%h want 1/%0d/%0d", k, rs_valid, iss_rd, iss_imm, iss_pc, 5 + k, k); end
        end
        tick();
        n_tests++; if (rob_valid !== 0 || if_ready !== 1) begin n_fail++;
            $display("FAIL fill_drop5th: got rob_valid=%b if_ready=%b want 0/1", rob_valid, if_ready); end
    endtask

    task automatic test_flush();
        set_idle();
        rs_ready = 0;
        enq(enc_addi(1, 0, 1), 32'h0);
        enq(enc_addi(2, 0, 2), 32'h4);
        rs_ready = 1; flush = 1; if_valid = 1; if_instr = enc_addi(10, 0, 10);
        @(negedge clk);
        n_tests++; if (rename_we !== 0) begin n_fail++;
            $display("FAIL flush_rename: got %b want 0", rename_we); end
        tick();
        flush = 0; if_valid = 0;
        n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== 3'b000 || if_ready !== 1) begin n_fail++;
            $display("FAIL flush_state: got %b if_ready=%b want 000/1", {rs_valid, lsb_valid, rob_valid}, if_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (rob_valid !== 0) begin n_fail++;
                $display("FAIL flush_empty_%0d: got rob_valid=%b want 0", i, rob_valid); end
        end
    endtask

    task automatic test_illegal();
        set_idle();
        rs_ready = 0; lsb_ready = 0; rob_free_tag = 7;
        enq(32'hFFFF_FFFF, 32'h20);
        @(negedge clk);
        n_tests++; if (rename_we !== 0) begin n_fail++;
            $display("FAIL ill_rename: got %b want 0", rename_we); end
        tick();
        n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== 3'b001 || iss_illegal !== 1) begin n_fail++;
            $display("FAIL ill_issue: got %b ill=%b want 001/1", {rs_valid, lsb_valid, rob_valid}, iss_illegal); end
        n_tests++; if (iss_op !== 6'(OP_NOP) || iss_rd !== 0 || iss_tag !== 4'd7 || iss_pc !== 32'h20) begin n_fail++;
            $display("FAIL ill_payload: got op=%0d rd=%0d tag=%0d pc=%h want 0/0/7/20", iss_op, iss_rd, iss_tag, iss_pc); end
    endtask

    task automatic test_back_to_back();
        set_idle();
        rs_ready = 0; rob_free_tag = 5;
        enq(enc_addi(3, 0, 7), 32'h40);
        enq(enc_addi(4, 3, 1), 32'h44);
        rs_ready = 1;
        @(negedge clk);
        n_tests++; if ({rename_we, rename_rd, rename_tag} !== {1'b1, 5'd3, 4'd5}) begin n_fail++;
            $display("FAIL b2b_rename1: got we=%b rd=%0d tag=%0d want 1/3/5", rename_we, rename_rd, rename_tag); end
        tick();
        reg_rs1_busy = 1; reg_rs1_tag = 5; rob_free_tag = 6;
        @(negedge clk);
        n_tests++; if (rob_q1_tag !== 4'd5 || rename_rd !== 5'd4 || rename_tag !== 4'd6) begin n_fail++;
            $display("FAIL b2b_rename2: got qtag=%0d rd=%0d tag=%0d want 5/4/6", rob_q1_tag, rename_rd, rename_tag); end
        tick();
        n_tests++; if (rs_valid !== 1 || iss_q1v !== 1 || iss_q1 !== 4'd5 || iss_tag !== 4'd6 || iss_rd !== 5'd4) begin n_fail++;
            $display("FAIL b2b_issue: got v=%b q1v=%b q1=%0d tag=%0d rd=%0d want 1/1/5/6/4", rs_valid, iss_q1v, iss_q1, iss_tag, iss_rd); end
    endtask

    task automatic test_rdy_hold();
        set_idle();
        enq(enc_addi(6, 0, 3), 32'h80);
        tick();
        rdy = 0; if_valid = 1; if_instr = enc_addi(7, 0, 1);
        tick();
        n_tests++; if (rs_valid !== 1 || iss_rd !== 5'd6 || rename_we !== 0) begin n_fail++;
            $display("FAIL rdy_hold: got v=%b rd=%0d we=%b want 1/6/0", rs_valid, iss_rd, rename_we); end
        rdy = 1; if_valid = 0;
        tick(); tick();
        n_tests++; if (rob_valid !== 0) begin n_fail++;
            $display("FAIL rdy_noenq: got rob_valid=%b want 0", rob_valid); end
    endtask

    task automatic test_reset_mid();
        set_idle();
        rs_ready = 0;
        for (int k = 0; k < DEPTH; k++) enq(enc_addi(1, 0, k), 32'h0);
        #2 rst = 0;
        #1;
        n_tests++; if (if_ready !== 1 || rob_valid !== 0) begin n_fail++;
            $display("FAIL reset_mid: got if_ready=%b rob_valid=%b want 1/0", if_ready, rob_valid); end
        tick();
        rst = 1; rs_ready = 1;
        tick(); tick();
        n_tests++; if (rob_valid !== 0) begin n_fail++;
            $display("FAIL reset_mid_empty: got rob_valid=%b want 0", rob_valid); end
    endtask

    task automatic test_random(input int n);
        logic [31:0] ins, pc, imm, v1, v2;
        logic [4:0]  rd;
        logic [ROB_W-1:0] q1, q2;
        int op;
        bit u1, u2, ill, ls, qv1, qv2, fired, exp_fire;
        for (int t = 0; t < n; t++) begin
            set_idle();
            ins = $urandom;
            case ($urandom_range(0, 9))
                0: ins[6:0] = 7'h37;  1: ins[6:0] = 7'h17;  2: ins[6:0] = 7'h6F;
                3: ins[6:0] = 7'h67;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h03;
                6: ins[6:0] = 7'h23;  7: ins[6:0] = 7'h13;  8: ins[6:0] = 7'h33;
                default: ;
            endcase
            if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
                ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if (ins[6:0] == 7'h67 && $urandom_range(0, 1) != 0) ins[14:12] = 3'd0;
            pc = $urandom & 32'hFFFF_FFFC;
            reg_rs1_busy = 1'($urandom); reg_rs2_busy = 1'($urandom);
            reg_rs1_tag = 4'($urandom); reg_rs2_tag = 4'($urandom);
            reg_rs1_val = $urandom; reg_rs2_val = $urandom;
            rob_q1_ready = 1'($urandom); rob_q2_ready = 1'($urandom);
            rob_q1_val = $urandom; rob_q2_val = $urandom;
            rob_free_tag = 4'($urandom);
            rs_ready = 0; lsb_ready = 0;
            ref_decode(ins, op, imm, rd, u1, u2, ill, ls);
            ref_operand(u1, ins[19:15], reg_rs1_busy, reg_rs1_tag, reg_rs1_val, rob_q1_ready, rob_q1_val, v1, qv1, q1);
            ref_operand(u2, ins[24:20], reg_rs2_busy, reg_rs2_tag, reg_rs2_val, rob_q2_ready, rob_q2_val, v2, qv2, q2);
            enq(ins, pc);
            fired = 0;
            for (int c = 0; c < 8 && !fired; c++) begin
                rs_ready = (c == 7) ? 1'b1 : 1'($urandom);
                lsb_ready = (c == 7) ? 1'b1 : 1'($urandom);
                rob_free_valid = (c == 7) ? 1'b1 : 1'($urandom);
                exp_fire = rob_free_valid && (ill || (ls ? lsb_ready : rs_ready));
                @(negedge clk);
                n_tests++; if (rename_we !== (exp_fire && rd != 0) || (exp_fire && rd != 0 && (rename_rd !== rd || rename_tag !== rob_free_tag))) begin n_fail++;
                    $display("FAIL rnd_rename ins=%h: got we=%b rd=%0d want we=%b rd=%0d", ins, rename_we, rename_rd, exp_fire && rd != 0, rd); end
                tick();
                n_tests++; if ({rs_valid, lsb_valid, rob_valid} !== (exp_fire ? {!ill && !ls, !ill && ls, 1'b1} : 3'b000)) begin n_fail++;
                    $display("FAIL rnd_valids ins=%h: got %b want fire=%b ill=%b ls=%b", ins, {rs_valid, lsb_valid, rob_valid}, exp_fire, ill, ls); end
                if (exp_fire) begin
                    n_tests++; if (iss_op !== 6'(op) || iss_imm !== imm || iss_rd !== rd || iss_illegal !== ill || iss_pc !== pc || iss_tag !== rob_free_tag) begin n_fail++;
                        $display("FAIL rnd_decode ins=%h: got op=%0d imm=%h rd=%0d ill=%b want op=%0d imm=%h rd=%0d ill=%b", ins, iss_op, iss_imm, iss_rd, iss_illegal, op, imm, rd, ill); end
                    n_tests++; if (iss_q1v !== qv1 || iss_q2v !== qv2 || (qv1 && iss_q1 !== q1) || (qv2 && iss_q2 !== q2) || (!qv1 && iss_v1 !== v1) || (!qv2 && iss_v2 !== v2)) begin n_fail++;
                        $display("FAIL rnd_operands ins=%h: got q1v=%b v1=%h q2v=%b v2=%h want q1v=%b v1=%h q2v=%b v2=%h", ins, iss_q1v, iss_v1, iss_q2v, iss_v2, qv1, v1, qv2, v2); end
                end
                fired = exp_fire;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_operands();
        test_store_stall();
        test_fill_wrap();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_rdy_hold();
        test_reset_mid();
        test_random(300);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
